// File: rtl/pueo_run_pkg.sv
// Shared types and constants for the TURFIO run-state sequencer.
//  run_state_t      : 2-bit run state (IDLE/RESETTING/ARMED/RUNNING)
//  RUN_STATE_*      : raw encodings as seen on run_state_o
//  trig_entry_t     : {event number, trigger time} at default widths
package pueo_run_pkg;

  localparam int unsigned TRIG_BITS_DEF  = 48;
  localparam int unsigned EVENT_BITS_DEF = 32;
  localparam int unsigned ENTRY_W_DEF    = EVENT_BITS_DEF + TRIG_BITS_DEF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RESETTING = 2'd1,
    ARMED     = 2'd2,
    RUNNING   = 2'd3
  } run_state_t;

  localparam logic [1:0] RUN_STATE_IDLE      = 2'd0;
  localparam logic [1:0] RUN_STATE_RESETTING = 2'd1;
  localparam logic [1:0] RUN_STATE_ARMED     = 2'd2;
  localparam logic [1:0] RUN_STATE_RUNNING   = 2'd3;

  typedef struct packed {
    logic [EVENT_BITS_DEF-1:0] event_num;
    logic [TRIG_BITS_DEF-1:0]  trig_time;
  } trig_entry_t;

endpackage

// File: rtl/pueo_turfio_run_control_if.sv
// AXI-Stream style trigger stream carrying {event number, trigger time}.
//  tdata  : entry payload (master -> slave)
//  tvalid : entry present (master -> slave)
//  tready : consumer accepts head entry (slave -> master)
interface pueo_turfio_run_control_if
  import pueo_run_pkg::*;
#(
  parameter int unsigned DATA_W = ENTRY_W_DEF
);

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/pueo_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//  clk_i/rst_i : clock, synchronous active-high reset
//  push_i/data_i : write request and data (ignored when full unless popping)
//  pop_i       : consume head entry (ignored when empty)
//  flush_i     : discard all entries; wins over push/pop
//  data_o      : head entry, valid while !empty_o
//  full_o/empty_o : registered occupancy flags
module pueo_sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, empty_q;
  logic              do_push, do_pop;

  // A pop in the same cycle frees the slot, so push is legal when full
  always_comb begin
    do_push = push_i && (!full_q || pop_i);
    do_pop  = pop_i && !empty_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage needs no reset; occupancy flags gate its visibility
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/pueo_turfio_run_control.sv
// Run-state sequencer behind the TURFIO rackbus command decoder.
//  sysclk_i/sysrst_i    : clock, synchronous active-high reset
//  sync_i/reset_i/stop_i: decoded run commands (pulses), priority reset > stop > sync
//  pps_i                : PPS pulse, counted while RUNNING
//  trig_time_i/_valid_i : trigger time strobe, accepted while RUNNING
//  run_state_o          : IDLE=0 RESETTING=1 ARMED=2 RUNNING=3
//  run_reset_o          : high for RESET_LEN cycles while RESETTING
//  running_o            : state is RUNNING
//  sec_count_o          : PPS count since SYNC
//  overflow_count_o     : triggers dropped on full FIFO, saturating
//  trig_if (master)     : {event number, trig time} stream
module pueo_turfio_run_control
  import pueo_run_pkg::*;
#(
  parameter int unsigned TRIG_BITS  = TRIG_BITS_DEF,
  parameter int unsigned EVENT_BITS = EVENT_BITS_DEF,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned RESET_LEN  = 16
) (
  input  logic                 sysclk_i,
  input  logic                 sysrst_i,
  input  logic                 sync_i,
  input  logic                 reset_i,
  input  logic                 stop_i,
  input  logic                 pps_i,
  input  logic [TRIG_BITS-1:0] trig_time_i,
  input  logic                 trig_time_valid_i,
  output logic [1:0]           run_state_o,
  output logic                 run_reset_o,
  output logic                 running_o,
  output logic [31:0]          sec_count_o,
  output logic [15:0]          overflow_count_o,
  pueo_turfio_run_control_if.master trig_if
);

  localparam int unsigned ENTRY_W = EVENT_BITS + TRIG_BITS;
  localparam int unsigned CNT_W   = (RESET_LEN > 1) ? $clog2(RESET_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESET_LEN - 1);

  run_state_t            state_q, state_d;
  logic [CNT_W-1:0]      rst_cnt_q, rst_cnt_d;
  logic [EVENT_BITS-1:0] evt_q, evt_d;
  logic [31:0]           sec_q, sec_d;
  logic [15:0]           ovf_q, ovf_d;
  logic                  run_reset_q, running_q;

  logic                  fifo_push, fifo_pop, fifo_flush;
  logic                  fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]    fifo_dout;
  logic                  trig_acc;

  assign fifo_pop = !fifo_empty && trig_if.tready;

  // State, counters and registered status outputs
  always_ff @(posedge sysclk_i) begin
    if (sysrst_i) begin
      state_q     <= IDLE;
      rst_cnt_q   <= '0;
      evt_q       <= '0;
      sec_q       <= '0;
      ovf_q       <= '0;
      run_reset_q <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      evt_q       <= evt_d;
      sec_q       <= sec_d;
      ovf_q       <= ovf_d;
      run_reset_q <= (state_d == RESETTING);
      running_q   <= (state_d == RUNNING);
    end
  end

  // Next-state, counter updates and trigger push/drop decisions
  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    evt_d      = evt_q;
    sec_d      = sec_q;
    ovf_d      = ovf_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    // A trigger alongside reset_i is discarded outright
    trig_acc   = trig_time_valid_i && (state_q == RUNNING) && !reset_i;

    if (reset_i) begin
      state_d    = RESETTING;
      rst_cnt_d  = CNT_LOAD;
      fifo_flush = 1'b1;
      evt_d      = '0;
      sec_d      = '0;
      ovf_d      = '0;
    end else begin
      case (state_q)
        RESETTING: begin
          if (rst_cnt_q == '0) state_d = ARMED;
          else                 rst_cnt_d = rst_cnt_q - CNT_W'(1);
        end
        ARMED: begin
          // stop_i outranks sync_i even though stop is a no-op here
          if (sync_i && !stop_i) begin
            state_d = RUNNING;
            sec_d   = '0;
          end
        end
        RUNNING: begin
          if (stop_i) state_d = IDLE;
          if (pps_i)  sec_d   = sec_q + 32'd1;
        end
        IDLE: ;
      endcase

      // Event numbers advance even when the entry itself is dropped
      if (trig_acc) begin
        evt_d = evt_q + EVENT_BITS'(1);
        if (!fifo_full || fifo_pop)    fifo_push = 1'b1;
        else if (ovf_q != 16'hFFFF)    ovf_d     = ovf_q + 16'd1;
      end
    end
  end

  pueo_sync_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (sysclk_i),
    .rst_i   (sysrst_i),
    .push_i  (fifo_push),
    .data_i  ({evt_q, trig_time_i}),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign trig_if.tdata    = fifo_dout;
  assign trig_if.tvalid   = !fifo_empty;
  assign run_state_o      = state_q;
  assign run_reset_o      = run_reset_q;
  assign running_o        = running_q;
  assign sec_count_o      = sec_q;
  assign overflow_count_o = ovf_q;

endmodule
